// File: rtl/md_sequencer_if.sv
// Request/control bundle between the processor, the sequencer
// and the multiply/divide datapath.
interface md_sequencer_if #(
  parameter int CW = 6
);
  logic          ctrl_mult;
  logic          ctrl_div;
  logic          div_zero;
  logic          mult_ovf;
  logic          load;
  logic          step_en;
  logic          is_div;
  logic [CW-1:0] count;
  logic          cnt_in_en;
  logic          cnt_oe;
  logic          busy;
  logic          result_ready;
  logic          exception;

  modport master (
    output ctrl_mult, ctrl_div,
    output div_zero, mult_ovf,
    input  load, step_en, is_div,
    input  count, cnt_in_en, cnt_oe,
    input  busy, result_ready, exception
  );

  modport slave (
    input  ctrl_mult, ctrl_div,
    input  div_zero, mult_ovf,
    output load, step_en, is_div,
    output count, cnt_in_en, cnt_oe,
    output busy, result_ready, exception
  );
endinterface

// File: rtl/md_sequencer.sv
// Control sequencer for the iterative multiply/divide datapath:
// load, ITERS step cycles, then a one-cycle result strobe.
module md_sequencer #(
  parameter int ITERS = 32,
  parameter int CW    = 6
) (
  input logic           clock,
  input logic           reset,
  md_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [1:0]    st;
  logic [1:0]    st_nx;
  logic [CW-1:0] cnt;
  logic          isdiv;
  logic          dz;
  logic          req;

  // Exactly one request line; mult+div together is ignored.
  assign req = bus.ctrl_mult ^ bus.ctrl_div;

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: st_nx = IDLE;
      LOAD: st_nx = (isdiv && bus.div_zero) ? DONE : RUN;
      RUN:  st_nx = (cnt == LAST) ? DONE : RUN;
      DONE: st_nx = IDLE;
    endcase
    if (req) st_nx = LOAD;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      cnt   <= '0;
      isdiv <= 1'b0;
      dz    <= 1'b0;
    end else begin
      st <= st_nx;
      if (req) begin
        isdiv <= bus.ctrl_div;
        cnt   <= '0;
        dz    <= 1'b0;
      end else begin
        if (st == RUN && cnt != LAST) cnt <= cnt + 1'b1;
        if (st == LOAD) dz <= isdiv & bus.div_zero;
      end
    end
  end

  assign bus.load         = (st == LOAD);
  assign bus.step_en      = (st == RUN);
  assign bus.cnt_in_en    = (st == LOAD) || (st == RUN);
  assign bus.cnt_oe       = (st == RUN);
  assign bus.busy         = (st != IDLE);
  assign bus.result_ready = (st == DONE);
  assign bus.is_div       = isdiv;
  assign bus.count        = cnt;
  // Overflow is only valid from the datapath in the strobe cycle.
  assign bus.exception    = (st == DONE) &&
                            (isdiv ? dz : bus.mult_ovf);
endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: vector table plus
// scoreboard of expected result strobes.
module tb_md_sequencer;
  localparam int ITERS = 32;
  localparam int CW    = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;

  md_sequencer_if #(.CW(CW)) bus();

  md_sequencer #(.ITERS(ITERS), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   lat;
    logic exc;
    logic isdiv;
  } exp_t;

  typedef struct {
    logic m;
    logic d;
    logic z;
    logic o;
    int   lat;
    logic exc;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_load"}, bus.load, 0);
    chk({nm, "_step"}, bus.step_en, 0);
    chk({nm, "_isdiv"}, bus.is_div, 0);
    chk({nm, "_count"}, bus.count, 0);
    chk({nm, "_cnt_in_en"}, bus.cnt_in_en, 0);
    chk({nm, "_cnt_oe"}, bus.cnt_oe, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_rr"}, bus.result_ready, 0);
    chk({nm, "_exc"}, bus.exception, 0);
  endtask

  // Issue one request and follow it to its result strobe.
  // Optionally inject a second request when count == inj_at.
  task automatic run_op(input logic m, input logic d,
                        input logic z, input logic o,
                        input int lat, input logic exc,
                        input int inj_at,
                        input logic im, input logic id);
    exp_t e;
    int   cyc;
    int   stp;
    bit   done;
    bit   inj;
    bus.div_zero = z;
    bus.mult_ovf = o;
    e.lat   = lat;
    e.exc   = exc;
    e.isdiv = d;
    sb.push_back(e);
    bus.ctrl_mult = m;
    bus.ctrl_div  = d;
    tick();
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    chk("load_first", bus.load, 1);
    chk("count_load", bus.count, 0);
    cyc  = 1;
    stp  = 0;
    done = 0;
    inj  = 0;
    while (!done && cyc < 200) begin
      chk("onehot", $countones({bus.load, bus.step_en,
                                bus.result_ready}) <= 1, 1);
      chk("exc_qual", bus.exception & ~bus.result_ready, 0);
      chk("cnt_oe", bus.cnt_oe, bus.step_en);
      chk("cnt_in_en", bus.cnt_in_en, bus.load | bus.step_en);
      chk("busy", bus.busy, 1);
      if (bus.step_en) begin
        chk("count", bus.count, stp);
        stp++;
      end
      if (bus.result_ready) begin
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("exception", bus.exception, e.exc);
        chk("is_div", bus.is_div, e.isdiv);
        chk("steps", stp, e.lat - 2);
        done = 1;
      end else if (bus.step_en && inj_at >= 0 && !inj &&
                   int'(bus.count) == inj_at) begin
        inj = 1;
        bus.ctrl_mult = im;
        bus.ctrl_div  = id;
        tick();
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        if (im ^ id) begin
          e = sb.pop_front();
          e.isdiv = id;
          sb.push_back(e);
          chk("restart_load", bus.load, 1);
          chk("restart_count", bus.count, 0);
          chk("restart_isdiv", bus.is_div, id);
          cyc = 1;
          stp = 0;
        end else begin
          cyc++;
        end
      end else begin
        tick();
        cyc++;
      end
    end
    chk("no_timeout", done, 1);
    tick();
    chk("busy_after", bus.busy, 0);
    chk("rr_after", bus.result_ready, 0);
    bus.div_zero = 1'b0;
    bus.mult_ovf = 1'b0;
  endtask

  initial begin
    int k;
    tbl[0] = '{m: 1, d: 0, z: 0, o: 0, lat: 34, exc: 0};
    tbl[1] = '{m: 1, d: 0, z: 0, o: 1, lat: 34, exc: 1};
    tbl[2] = '{m: 0, d: 1, z: 0, o: 0, lat: 34, exc: 0};
    tbl[3] = '{m: 0, d: 1, z: 1, o: 0, lat: 2,  exc: 1};
    tbl[4] = '{m: 0, d: 1, z: 0, o: 1, lat: 34, exc: 0};
    tbl[5] = '{m: 1, d: 0, z: 1, o: 0, lat: 34, exc: 0};

    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.div_zero  = 1'b0;
    bus.mult_ovf  = 1'b0;
    #2;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk_zero("post_reset");

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].m, tbl[i].d, tbl[i].z, tbl[i].o,
             tbl[i].lat, tbl[i].exc, -1, 1'b0, 1'b0);

    // Both requests in IDLE; last op was a multiply.
    bus.ctrl_mult = 1'b1;
    bus.ctrl_div  = 1'b1;
    tick();
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    chk("both_idle_busy", bus.busy, 0);
    chk("both_idle_load", bus.load, 0);
    chk("both_idle_isdiv", bus.is_div, 0);
    tick();
    chk("both_idle_busy2", bus.busy, 0);

    run_op(0, 1, 0, 0, 34, 0, 5, 1'b0, 1'b1);
    run_op(1, 0, 0, 0, 34, 0, 7, 1'b1, 1'b1);

    // New request in the strobe cycle goes straight to LOAD.
    bus.ctrl_mult = 1'b1;
    tick();
    bus.ctrl_mult = 1'b0;
    k = 0;
    while (!bus.result_ready && k < 60) begin
      tick();
      k++;
    end
    chk("b2b_first_rr", bus.result_ready, 1);
    chk("b2b_first_lat", k + 1, 34);
    bus.ctrl_div = 1'b1;
    bus.div_zero = 1'b1;
    tick();
    bus.ctrl_div = 1'b0;
    chk("b2b_load", bus.load, 1);
    chk("b2b_isdiv", bus.is_div, 1);
    tick();
    bus.div_zero = 1'b0;
    chk("b2b_rr", bus.result_ready, 1);
    chk("b2b_exc", bus.exception, 1);
    tick();
    chk("b2b_idle", bus.busy, 0);

    // Asynchronous reset in the middle of RUN.
    bus.ctrl_div = 1'b1;
    tick();
    bus.ctrl_div = 1'b0;
    k = 0;
    while (!(bus.step_en && bus.count == 10) && k < 60) begin
      tick();
      k++;
    end
    chk("midrun_reach", bus.count, 10);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("midrun_reset");
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk_zero("midrun_release");
    run_op(1, 0, 0, 0, 34, 0, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
